// File: rtl/shift_unit_arbiter_pkg.sv
// ============================================================================
//  Module      : shift_arb_pkg
//  Description : Shared types and widths for the shift unit arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_arb_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_RSVD = 2'b11
    } shift_op_e;

    // Reserved op passes the operand through, so its shift amount is zeroed.
    function automatic logic [SHAMT_W-1:0] eff_shamt(input shift_op_e op,
                                                     input logic [SHAMT_W-1:0] shamt);
        return (op == OP_RSVD) ? '0 : shamt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_unit_arbiter_if.sv
// ============================================================================
//  Module      : shift_unit_arbiter_if
//  Description : Request/response bus between requesters and the shift unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_unit_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]                        req_valid;
    logic [NUM_REQ-1:0]                        req_ready;
    logic [NUM_REQ*2-1:0]                      req_op;
    logic [NUM_REQ*shift_arb_pkg::XLEN-1:0]    req_data;
    logic [NUM_REQ*shift_arb_pkg::SHAMT_W-1:0] req_shamt;
    logic [NUM_REQ-1:0]                        rsp_valid;
    logic [NUM_REQ-1:0]                        rsp_ready;
    logic [shift_arb_pkg::XLEN-1:0]            rsp_data;

    modport master (
        output req_valid, req_op, req_data, req_shamt, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_data, req_shamt, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

`default_nettype wire

// File: rtl/shift_unit_arbiter_rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : One-hot grant among requesters. Round robin by default;
//                fixed priority (lowest index wins) when
//                SHIFT_ARB_FIXED_PRIO_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  wire                clk,
    input  wire                rst_n,
    input  wire  [NUM_REQ-1:0] i_req,
    input  wire                i_advance,
    output logic [NUM_REQ-1:0] o_grant
);
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    logic w_unused_ok;
    logic w_found;

    assign w_unused_ok = &{1'b0, clk, rst_n, i_advance};

    // Lowest-index requester wins.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i]) begin
                o_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end
`else
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             w_found;
    int               idx;

    // Search from the pointer, wrapping; next pointer is one past the winner.
    always_comb begin
        o_grant   = '0;
        w_found   = 1'b0;
        w_ptr_nxt = r_ptr;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_found && i_req[idx]) begin
                o_grant[idx] = 1'b1;
                w_found      = 1'b1;
                w_ptr_nxt    = (idx == NUM_REQ-1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    // Pointer moves only when the granted request is actually accepted.
    always_ff @(posedge clk) begin
        if (!rst_n)         r_ptr <= '0;
        else if (i_advance) r_ptr <= w_ptr_nxt;
    end
`endif
endmodule

`default_nettype wire

// File: rtl/shift_unit_arbiter_shifter.sv
// ============================================================================
//  Module      : barrel_shifter_optimized
//  Description : Combinational log-stage barrel shifter (SLL/SRL/SRA). Left
//                shifts reuse the right-shift stages by bit-reversing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_shifter_optimized
    import shift_arb_pkg::*;
(
    input  wire  [XLEN-1:0]    i_data,
    input  wire  [SHAMT_W-1:0] i_shamt,
    input  wire                i_right,
    input  wire                i_arith,
    output logic [XLEN-1:0]    o_data
);
    logic [XLEN-1:0] w_in_rev;
    logic [XLEN-1:0] w_out_rev;
    logic [XLEN-1:0] w_stage [SHAMT_W+1];
    logic            w_fill;

    for (genvar b = 0; b < XLEN; b++) begin : g_rev
        assign w_in_rev[b]  = i_data[XLEN-1-b];
        assign w_out_rev[b] = w_stage[SHAMT_W][XLEN-1-b];
    end

    assign w_stage[0] = i_right ? i_data : w_in_rev;
    assign w_fill     = i_right & i_arith & i_data[XLEN-1];

    for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
        localparam int SH = 1 << s;
        assign w_stage[s+1] = i_shamt[s] ? {{SH{w_fill}}, w_stage[s][XLEN-1:SH]}
                                         : w_stage[s];
    end

    assign o_data = i_right ? w_stage[SHAMT_W] : w_out_rev;

endmodule

`default_nettype wire

// File: rtl/shift_unit_arbiter.sv
// ============================================================================
//  Module      : shift_unit_arbiter
//  Description : Shares one barrel shifter between NUM_REQ requesters with a
//                two-stage (operand reg -> result reg) pipeline. Build macro
//                SHIFT_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_unit_arbiter
    import shift_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  wire                 clk,
    input  wire                 rst_n,
    shift_unit_arbiter_if.slave bus
);
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [NUM_REQ-1:0] w_rsp_valid;
    logic               w_s2_free;
    logic               w_s1_adv;
    logic               w_s1_accept;
    logic               w_accept;
    shift_op_e          w_sel_op;
    logic [XLEN-1:0]    w_sel_data;
    logic [SHAMT_W-1:0] w_sel_shamt;
    logic [XLEN-1:0]    w_shift_out;

    shift_op_e          r_s1_op;
    logic [XLEN-1:0]    r_s1_data;
    logic [SHAMT_W-1:0] r_s1_shamt;
    logic [NUM_REQ-1:0] r_s1_owner;
    logic               r_s1_valid;
    logic [XLEN-1:0]    r_s2_data;
    logic [NUM_REQ-1:0] r_s2_owner;
    logic               r_s2_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (bus.req_valid),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

    // Owners are tracked one-hot so rsp_valid is the owner field itself.
    assign w_rsp_valid   = {NUM_REQ{r_s2_valid}} & r_s2_owner;
    assign w_s2_free     = !r_s2_valid || (|(w_rsp_valid & bus.rsp_ready));
    assign w_s1_adv      = r_s1_valid && w_s2_free;
    assign w_s1_accept   = !r_s1_valid || w_s1_adv;
    // Held low during reset so nothing is accepted on a reset edge.
    assign w_req_ready   = w_grant & {NUM_REQ{w_s1_accept & rst_n}};
    assign w_accept      = |(w_req_ready & bus.req_valid);

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_data  = r_s2_data;

    // Route the granted requester's operands toward stage 1.
    always_comb begin
        w_sel_op    = OP_SLL;
        w_sel_data  = '0;
        w_sel_shamt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_op    = shift_op_e'(bus.req_op[i*2 +: 2]);
                w_sel_data  = bus.req_data[i*XLEN +: XLEN];
                w_sel_shamt = bus.req_shamt[i*SHAMT_W +: SHAMT_W];
            end
        end
    end

    barrel_shifter_optimized u_shifter (
        .i_data  (r_s1_data),
        .i_shamt (eff_shamt(r_s1_op, r_s1_shamt)),
        .i_right ((r_s1_op == OP_SRL) || (r_s1_op == OP_SRA)),
        .i_arith (r_s1_op == OP_SRA),
        .o_data  (w_shift_out)
    );

    // Stage 1: capture the accepted operation whenever the slot frees up.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_SLL;
            r_s1_data  <= '0;
            r_s1_shamt <= '0;
            r_s1_owner <= '0;
        end else if (w_s1_accept) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_op    <= w_sel_op;
                r_s1_data  <= w_sel_data;
                r_s1_shamt <= w_sel_shamt;
                r_s1_owner <= w_grant;
            end
        end
    end

    // Stage 2: result register, held until its owner consumes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_owner <= '0;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data  <= w_shift_out;
                r_s2_owner <= r_s1_owner;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shift_unit_arbiter.sv
// ============================================================================
//  Module      : tb_shift_unit_arbiter
//  Description : Directed self-checking bench for shift_unit_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_unit_arbiter;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    shift_unit_arbiter_if #(.NUM_REQ(2)) bus ();

    shift_unit_arbiter #(.NUM_REQ(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op,
                           input logic [31:0] data, input logic [4:0] shamt);
        bus.req_valid[i]          = v;
        bus.req_op[i*2 +: 2]      = op;
        bus.req_data[i*32 +: 32]  = data;
        bus.req_shamt[i*5 +: 5]   = shamt;
    endtask

    // Requester 0 issues one op with rsp_ready high; result checked 2 edges later.
    task automatic run_single(input string tag, input logic [1:0] op,
                              input logic [31:0] data, input logic [4:0] shamt,
                              input logic [31:0] exp);
        set_req(0, 1'b1, op, data, shamt);
        #1;
        chk({tag, "_ready"}, {30'd0, bus.req_ready}, 32'h1);
        tick();
        bus.req_valid = 2'b00;
        tick();
        chk({tag, "_rspv"}, {30'd0, bus.rsp_valid}, 32'h1);
        chk({tag, "_data"}, bus.rsp_data, exp);
        tick();
        chk({tag, "_drain"}, {30'd0, bus.rsp_valid}, 32'h0);
    endtask

    function automatic logic [1:0] exp_grant(input int k);
`ifdef SHIFT_ARB_FIXED_PRIO_EN
        return 2'b01;
`else
        return (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
    endfunction

    initial begin
        logic [1:0] g;
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_data  = '0;
        bus.req_shamt = '0;
        bus.rsp_ready = '0;

        // Reset state
        tick();
        tick();
        chk("rst_rspv",  {30'd0, bus.rsp_valid}, 32'h0);
        chk("rst_data",  bus.rsp_data, 32'h0);
        chk("rst_ready", {30'd0, bus.req_ready}, 32'h0);
        rst_n         = 1'b1;
        bus.rsp_ready = 2'b11;

        // Single SRL
        run_single("srl1", 2'b01, 32'hA5A5A5A5, 5'd1, 32'h52D2D2D2);

        // Fresh pointer, then both requesters held valid
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_req(0, 1'b1, 2'b10, 32'hA5A5A5A5, 5'd16);
        set_req(1, 1'b1, 2'b00, 32'hA5A5A5A5, 5'd16);
        #1;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("arb_grant%0d", k), {30'd0, bus.req_ready}, {30'd0, exp_grant(k)});
            tick();
            if (k >= 1) begin
                g = exp_grant(k-1);
                chk($sformatf("arb_rspv%0d", k), {30'd0, bus.rsp_valid}, {30'd0, g});
                chk($sformatf("arb_data%0d", k), bus.rsp_data,
                    (g == 2'b01) ? 32'hFFFFA5A5 : 32'hA5A50000);
            end
        end
        bus.req_valid = 2'b00;
        tick();
        chk("arb_last_rspv", {30'd0, bus.rsp_valid}, {30'd0, exp_grant(5)});
        tick();
        chk("arb_empty", {30'd0, bus.rsp_valid}, 32'h0);

        // Backpressure: rsp_ready low for 5 edges with req0 streaming
        bus.rsp_ready = 2'b00;
        set_req(0, 1'b1, 2'b00, 32'h00000011, 5'd4);
        #1;
        chk("bp_ready0", {30'd0, bus.req_ready}, 32'h1);
        tick();
        set_req(0, 1'b1, 2'b00, 32'h00000022, 5'd4);
        #1;
        chk("bp_ready1", {30'd0, bus.req_ready}, 32'h1);
        tick();
        set_req(0, 1'b1, 2'b00, 32'h00000033, 5'd4);
        #1;
        chk("bp_full_ready", {30'd0, bus.req_ready}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_hold_data%0d", k), bus.rsp_data, 32'h00000110);
            chk($sformatf("bp_hold_rspv%0d", k), {30'd0, bus.rsp_valid}, 32'h1);
            chk($sformatf("bp_hold_ready%0d", k), {30'd0, bus.req_ready}, 32'h0);
        end
        bus.rsp_ready = 2'b01;
        #1;
        chk("bp_release_ready", {30'd0, bus.req_ready}, 32'h1);
        tick();
        bus.req_valid = 2'b00;
        chk("bp_out1", bus.rsp_data, 32'h00000220);
        tick();
        chk("bp_out2", bus.rsp_data, 32'h00000330);
        chk("bp_out2_v", {30'd0, bus.rsp_valid}, 32'h1);
        tick();
        chk("bp_empty", {30'd0, bus.rsp_valid}, 32'h0);
        bus.rsp_ready = 2'b11;

        // Boundary operations
        run_single("rsvd",  2'b11, 32'h80000001, 5'd31, 32'h80000001);
        run_single("sra31", 2'b10, 32'h80000001, 5'd31, 32'hFFFFFFFF);
        run_single("srl31", 2'b01, 32'h80000001, 5'd31, 32'h00000001);
        run_single("sll31", 2'b00, 32'h00000001, 5'd31, 32'h80000000);

        // Reset with both stages full
        bus.rsp_ready = 2'b00;
        set_req(0, 1'b1, 2'b00, 32'h00000005, 5'd0);
        tick();
        tick();
        chk("full_rspv",  {30'd0, bus.rsp_valid}, 32'h1);
        chk("full_ready", {30'd0, bus.req_ready}, 32'h0);
        rst_n         = 1'b0;
        bus.req_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rstfull_rspv",  {30'd0, bus.rsp_valid}, 32'h0);
        chk("rstfull_ready", {30'd0, bus.req_ready}, 32'h0);
        chk("rstfull_data",  bus.rsp_data, 32'h0);
        bus.rsp_ready = 2'b11;
        run_single("resume", 2'b01, 32'hA5A5A5A5, 5'd4, 32'h0A5A5A5A);

        // Back-to-back: 8 ops on 8 consecutive edges
        for (int k = 0; k < 10; k++) begin
            if (k < 8) set_req(0, 1'b1, 2'b00, 32'(k + 1), 5'd1);
            else       bus.req_valid = 2'b00;
            #1;
            if (k < 8) chk($sformatf("b2b_ready%0d", k), {30'd0, bus.req_ready}, 32'h1);
            tick();
            if (k >= 1 && k <= 8) begin
                chk($sformatf("b2b_rspv%0d", k), {30'd0, bus.rsp_valid}, 32'h1);
                chk($sformatf("b2b_data%0d", k), bus.rsp_data, 32'(2 * k));
            end
            if (k == 9) chk("b2b_empty", {30'd0, bus.rsp_valid}, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
